// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
package arb_pkg;

   localparam int ARB_N     = 8;
   localparam int ARB_IDX_W = 3;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   // Rotating-priority pick: first set request bit starting at ptr and
   // wrapping modulo ARB_N. Returns a one-hot vector, all-zero when req is 0.
   function automatic logic [ARB_N-1:0] arb_rr_pick(
      input logic [ARB_N-1:0]     req,
      input logic [ARB_IDX_W-1:0] ptr
   );
      logic [ARB_N-1:0]     pick;
      logic [ARB_IDX_W-1:0] idx;
      pick = '0;
      for (int i = 0; i < ARB_N; i++) begin
         idx = ptr + ARB_IDX_W'(i);
         if (req[idx] && (pick == '0)) begin
            pick[idx] = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/arb_idx_enc.sv
// One-hot to binary index encoder with a valid flag; zero input gives index 0.
module arb_idx_enc
   import arb_pkg::*;
(
   input  logic [ARB_N-1:0]     onehot_i,
   output logic [ARB_IDX_W-1:0] idx_o,
   output logic                 valid_o
);

   // OR together the indices of all set bits (exactly one for a legal input)
   always_comb begin
      idx_o = '0;
      for (int i = 0; i < ARB_N; i++) begin
         if (onehot_i[i]) begin
            idx_o = idx_o | ARB_IDX_W'(i);
         end
      end
   end

   assign valid_o = |onehot_i;

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with grant hold until release or revoke.
// Optional forced revoke after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined;
// otherwise there is no hold counter and timeout is tied low.
//
// Handshake: a requester raises req[i] and keeps it high for the whole
// transaction; it owns the resource while grant[i] is high and ends the
// transaction by dropping req[i]. A grant never moves directly between
// requesters, so there is always at least one idle cycle between grants.
module rr_arbiter_8
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [ARB_N-1:0]     req,
   output logic [ARB_N-1:0]     grant,
   output logic [ARB_IDX_W-1:0] grant_idx,
   output logic                 grant_valid,
   output logic                 timeout,
   output arb_state_t           dbg_state_o,
   output logic [ARB_IDX_W-1:0] dbg_ptr_o
);

   if ((MAX_HOLD < 1) || (MAX_HOLD > 255)) begin : g_bad_max_hold
      $error("rr_arbiter_8: MAX_HOLD must be within 1..255");
   end

   arb_state_t           state_q, state_d;
   logic [ARB_N-1:0]     grant_q, grant_d;
   logic [ARB_IDX_W-1:0] idx_q, idx_d;
   logic [ARB_IDX_W-1:0] ptr_q, ptr_d;
   logic [ARB_N-1:0]     winner;
   logic [ARB_IDX_W-1:0] win_idx;
   logic                 win_valid;
   logic                 hold_expired;

   assign winner = arb_rr_pick(req, ptr_q);

   arb_idx_enc u_idx_enc (
      .onehot_i (winner),
      .idx_o    (win_idx),
      .valid_o  (win_valid)
   );

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   logic [7:0] hold_q, hold_d;
   logic       timeout_q, timeout_d;

   // Count cycles already spent granted; last cycle is MAX_HOLD-1 after issue
   assign hold_expired = (state_q == ARB_BUSY) && (hold_q == HOLD_LAST);

   // Hold counter: cleared on issue, incremented while the grant is kept;
   // timeout pulses only when expiry is the sole reason for leaving BUSY
   always_comb begin
      hold_d    = hold_q;
      timeout_d = 1'b0;
      if ((state_q == ARB_IDLE) && (state_d == ARB_BUSY)) begin
         hold_d = '0;
      end else if ((state_q == ARB_BUSY) && (state_d == ARB_BUSY)) begin
         hold_d = hold_q + 8'd1;
      end
      if (hold_expired && en && req[idx_q]) begin
         timeout_d = 1'b1;
      end
   end

   // Hold counter and timeout pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign hold_expired = 1'b0;
   assign timeout      = 1'b0;
`endif

   // Next-state: issue from IDLE in rotating order, drop to IDLE on
   // release, enable low or hold expiry; the pointer moves only on issue
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      case (state_q)
         ARB_IDLE: begin
            if (en && win_valid) begin
               state_d = ARB_BUSY;
               grant_d = winner;
               idx_d   = win_idx;
               ptr_d   = win_idx + ARB_IDX_W'(1);
            end
         end
         ARB_BUSY: begin
            if (!en || !req[idx_q] || hold_expired) begin
               state_d = ARB_IDLE;
               grant_d = '0;
               idx_d   = '0;
            end
         end
         default: begin
            state_d = ARB_IDLE;
            grant_d = '0;
            idx_d   = '0;
         end
      endcase
   end

   // State, grant, index and pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
      end
   end

   assign grant       = grant_q;
   assign grant_idx   = idx_q;
   assign grant_valid = |grant_q;
   assign dbg_state_o = state_q;
   assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8 (define ARB_TIMEOUT_EN to cover timeout).
module tb_rr_arbiter_8;
   import arb_pkg::*;

   localparam int TB_MAX_HOLD = 4;
   localparam int W           = 17;

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       timeout;
   arb_state_t dbg_state;
   logic [2:0] dbg_ptr;

   always #5 clk = ~clk;

   rr_arbiter_8 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .req         (req),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .timeout     (timeout),
      .dbg_state_o (dbg_state),
      .dbg_ptr_o   (dbg_ptr)
   );

   // ---------------- scoreboard state ----------------
   int         n_cmp = 0;
   int         n_err = 0;
   logic [W-1:0] exp_q[$];
   int         order[$];
   int         hi_cnt;
   int         to_cnt;

   // reference model of the arbiter
   logic m_busy;
   int   m_idx;
   int   m_ptr;
   int   m_cnt;
   logic m_to;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0;
      m_idx  = 0;
      m_ptr  = 0;
      m_cnt  = 0;
      m_to   = 1'b0;
   endtask

   // one clock edge of the reference behaviour, using the sampled inputs
   task automatic model_step();
      int win;
      m_to = 1'b0;
      if (!m_busy) begin
         if (en && (req != 8'h00)) begin
            win = -1;
            for (int k = 0; k < 8; k++) begin
               if ((win < 0) && req[(m_ptr + k) % 8]) win = (m_ptr + k) % 8;
            end
            m_busy = 1'b1;
            m_idx  = win;
            m_ptr  = (win + 1) % 8;
            m_cnt  = 1;
         end
      end else begin
         if (!en) begin
            m_busy = 1'b0;
         end else if (!req[m_idx]) begin
            m_busy = 1'b0;
`ifdef ARB_TIMEOUT_EN
         end else if (m_cnt == TB_MAX_HOLD) begin
            m_busy = 1'b0;
            m_to   = 1'b1;
         end else begin
            m_cnt++;
`endif
         end
      end
   endtask

   function automatic logic [W-1:0] model_pkt();
      logic [7:0] g;
      logic [2:0] ix;
      g  = m_busy ? (8'h01 << m_idx) : 8'h00;
      ix = m_busy ? 3'(m_idx) : 3'd0;
      return {3'(m_ptr), m_busy, m_to, m_busy, ix, g};
   endfunction

   // ---------------- driver tasks ----------------
   // Called at a negedge with inputs set; returns at the next negedge.
   task automatic step();
      logic [W-1:0] e;
      @(posedge clk);
      model_step();
      exp_q.push_back(model_pkt());
      #1;
      e = exp_q.pop_front();
      chk("grant", {24'h0, grant}, {24'h0, e[7:0]});
      chk("grant_idx", {29'h0, grant_idx}, {29'h0, e[10:8]});
      chk("grant_valid", {31'h0, grant_valid}, {31'h0, e[11]});
      chk("timeout", {31'h0, timeout}, {31'h0, e[12]});
      chk("state", {31'h0, (dbg_state == ARB_BUSY)}, {31'h0, e[13]});
      chk("ptr", {29'h0, dbg_ptr}, {29'h0, e[16:14]});
      hi_cnt += int'(grant_valid);
      to_cnt += int'(timeout);
      @(negedge clk);
   endtask

   task automatic do_reset();
      req   = 8'h00;
      en    = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // Requesters in `want` each keep their request until granted `hold`
   // cycles, then drop it for one edge and raise it again.
   task automatic run_agents(input logic [7:0] want, input int hold, input int cycles);
      int         held [8];
      logic [7:0] drop;
      logic       was_busy;
      for (int i = 0; i < 8; i++) held[i] = 0;
      drop = 8'h00;
      order.delete();
      for (int c = 0; c < cycles; c++) begin
         req      = want & ~drop;
         was_busy = m_busy;
         step();
         if (m_busy && !was_busy) order.push_back(int'(grant_idx));
         drop = 8'h00;
         if (m_busy) begin
            held[m_idx]++;
            if (held[m_idx] == hold) begin
               drop[m_idx] = 1'b1;
               held[m_idx] = 0;
            end
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int exp_81 [3];
      rst_n = 1'b0;
      en    = 1'b0;
      req   = 8'h00;
      model_reset();
      @(negedge clk);
      do_reset();

      // reset values
      chk("rst_grant", {24'h0, grant}, 32'h0);
      chk("rst_valid", {31'h0, grant_valid}, 32'h0);
      chk("rst_idx", {29'h0, grant_idx}, 32'h0);
      chk("rst_ptr", {29'h0, dbg_ptr}, 32'h0);
      chk("rst_timeout", {31'h0, timeout}, 32'h0);

      // no requests: stay idle
      en = 1'b1;
      repeat (10) step();

      // two competitors with 3-cycle transactions: 0, 7, 0
      exp_81 = '{0, 7, 0};
      run_agents(8'h81, 3, 12);
      chk("ord81_n", order.size(), 32'd3);
      for (int i = 0; i < 3; i++)
         chk("ord81", (i < order.size()) ? order[i] : -1, exp_81[i]);

      // all requesting, 2-cycle transactions: full rotation with wrap
      do_reset();
      en = 1'b1;
      run_agents(8'hFF, 2, 27);
      chk("ordFF_n", order.size(), 32'd9);
      for (int i = 0; i < 9; i++)
         chk("ordFF", (i < order.size()) ? order[i] : -1, i % 8);

      // late request is ignored until the holder releases
      do_reset();
      en  = 1'b1;
      req = 8'h08;
      step();
      chk("hold_idx", {29'h0, grant_idx}, 32'd3);
      req = 8'h18;
      repeat (2) step();
      chk("hold_keep", {24'h0, grant}, 32'h08);
      req = 8'h10;
      step();
      chk("rel_idle", {24'h0, grant}, 32'h00);
      step();
      chk("next_grant", {24'h0, grant}, 32'h10);

      // enable low revokes without moving the pointer
      do_reset();
      en  = 1'b1;
      req = 8'h08;
      step();
      en = 1'b0;
      step();
      chk("rev_grant", {24'h0, grant}, 32'h00);
      chk("rev_ptr", {29'h0, dbg_ptr}, 32'd4);
      en  = 1'b1;
      req = 8'h18;
      step();
      chk("rev_next", {29'h0, grant_idx}, 32'd4);

      // asynchronous reset mid-grant, then arbitration restarts at 0
      do_reset();
      en  = 1'b1;
      req = 8'h03;
      step();
      chk("mg_ptr", {29'h0, dbg_ptr}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mg_grant", {24'h0, grant}, 32'h0);
      chk("mg_valid", {31'h0, grant_valid}, 32'h0);
      chk("mg_idx", {29'h0, grant_idx}, 32'h0);
      chk("mg_ptr0", {29'h0, dbg_ptr}, 32'h0);
      chk("mg_timeout", {31'h0, timeout}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step();
      chk("mg_rearb", {24'h0, grant}, 32'h01);

`ifdef ARB_TIMEOUT_EN
      // lone continuous requester: 4 granted, timeout, 1 idle, repeat
      do_reset();
      en     = 1'b1;
      req    = 8'h04;
      hi_cnt = 0;
      to_cnt = 0;
      repeat (15) step();
      chk("to_hi_cnt", hi_cnt, 32'd12);
      chk("to_pulses", to_cnt, 32'd3);

      // enable low at the expiry edge suppresses the timeout pulse
      do_reset();
      en  = 1'b1;
      req = 8'h04;
      repeat (4) step();
      en = 1'b0;
      step();
      chk("en_over_to", {31'h0, timeout}, 32'h0);
      chk("en_over_gr", {24'h0, grant}, 32'h0);
`else
      // without forced revoke a grant is held indefinitely
      do_reset();
      en     = 1'b1;
      req    = 8'h04;
      hi_cnt = 0;
      to_cnt = 0;
      repeat (20) step();
      chk("nto_hi_cnt", hi_cnt, 32'd20);
      chk("nto_pulses", to_cnt, 32'd0);
`endif

      // ---------------- report ----------------
      chk("q_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter that shares one 8-way resource (the 8-to-3 encoded index path) among 8 requesters. Each cycle with the resource free, it picks one pending request in rotating priority. It holds that grant until the requester releases it, then presents the winner as both a one-hot grant and a 3-bit binary index. It sits in front of the shared encoder/mux datapath and is the single point deciding which source drives it.

## Interface
- `MAX_HOLD`, 16: maximum consecutive grant cycles before forced revoke; used only with `ARB_TIMEOUT_EN`; legal range 1..255.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: arbiter enable; low blocks new grants and revokes the current one.
- `req` input [7:0]: request lines; a requester holds its bit high for the whole transaction.
- `grant` output [7:0]: registered one-hot grant; all-zero when idle.
- `grant_idx` output [2:0]: binary index of the granted bit; 3'b000 when idle.
- `grant_valid` output 1: high while any grant is active.
- `timeout` output 1: one-cycle pulse when a grant is force-revoked; constant 0 without `ARB_TIMEOUT_EN`.

## Operation
- State machine has two states:
  - IDLE: no grant.
  - BUSY: exactly one grant bit is set.
- Rotating pointer `ptr` [2:0] holds the highest-priority index. Search order is ptr, ptr+1, …, 7, 0, …, ptr-1, modulo 8.
- IDLE → BUSY when `en`=1 and `req`≠0. The first set bit in search order wins. The arbiter sets `grant`, `grant_idx` and `grant_valid`, then sets `ptr` = winner+1 (7 wraps to 0).
- BUSY → IDLE when any of the following is sampled:
  - `req[grant_idx]`=0 (release);
  - `en`=0 (revoke);
  - with `ARB_TIMEOUT_EN`, the hold counter reaches `MAX_HOLD`.
- In BUSY, other `req` bits are ignored. The grant never switches directly from one requester to another.
- In IDLE, `en`=0 or `req`=0 means no change.
- `grant` and `grant_idx` always agree. `grant_valid` equals `|grant`.
- `ptr` advances only when a grant is issued. Release, revoke and timeout leave it unchanged.
- Reset values: state IDLE, `grant`=0, `grant_idx`=0, `grant_valid`=0, `timeout`=0, `ptr`=0 (req[0] has first priority), hold counter=0. Reset acts immediately and asynchronously, including mid-grant. After reset deasserts, the arbiter re-arbitrates from ptr=0.

## Timing
- Grant latency is 1 cycle. `req` sampled at edge k with the arbiter IDLE gives a grant visible after edge k.
- Release latency is 1 cycle. `req[i]` low at edge k drops `grant` after edge k.
- Minimum one IDLE cycle between consecutive grants. The next grant appears after edge k+1 at the earliest.
- A requester that drops and re-raises `req` in the same IDLE cycle competes normally. It is already behind the other requesters because `ptr` moved past it.
- A requester holding `req` continuously with no competitors is re-granted every second cycle after each revoke.
- `en` low at an edge overrides a simultaneous release or timeout. The arbiter goes to IDLE, and `timeout` stays 0 on that edge.
- Hold counter:
  - Cleared on every grant issue.
  - Increments each BUSY cycle.
  - Revoke happens at the edge where the count equals `MAX_HOLD`, so the grant is high for exactly `MAX_HOLD` cycles.
  - `timeout` pulses high for the cycle following that edge.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - 8-bit hold counter is present.
  - Forced revoke after `MAX_HOLD` cycles.
  - `timeout` pulses as described.
- `ARB_TIMEOUT_EN` undefined:
  - No counter logic.
  - A grant is held until release or `en`=0, however long that takes.
  - `timeout` is tied to 0.
  - `MAX_HOLD` is unused.

## Structure
- Shared package `arb_pkg` contains:
  - `ARB_N`=8 and `ARB_IDX_W`=3;
  - state enum `arb_state_t` {ARB_IDLE, ARB_BUSY};
  - function for the rotate-by-ptr search.
- One sub-module, `arb_idx_enc`: a purely combinational one-hot [7:0] to binary [2:0] encoder with a valid flag, used to derive `grant_idx` from the winner vector. Outputs 0 for zero input.

## Test plan
- Reset, then `req`=8'h00, `en`=1 → `grant`=0, `grant_valid`=0 for 10 cycles. Then `rst_n` pulsed low mid-grant → all outputs 0 immediately.
- `req`=8'h81 held, each winner releasing after 3 cycles → grants alternate: idx 0, then 7, then 0. One idle cycle appears between grants.
- `req`=8'hFF with each requester holding 2 cycles → grant order 0,1,…,7,0. Pointer wraps 7→0.
- Grant to idx 3 active, then `en`=0 → `grant`=0 next cycle, `ptr` remains 4. With `en`=1 again and `req`=8'h18, idx 4 wins.
- Grant active, `req[4]` raised mid-grant → no change to `grant` until idx 3 releases.
- With `ARB_TIMEOUT_EN` and `MAX_HOLD`=4, `req`=8'h04 held forever → grant high 4 cycles, `timeout` pulses once, 1 idle cycle, then re-granted. Repeats indefinitely.
